// File: rtl/crc32_pkg.sv
// Shared CRC-32/MPEG-2 constants, bit-serial step function and checker state encoding.
// The transmit-side generator is expected to reuse crc32_mpeg2_step.
package crc32_pkg;

   localparam logic [31:0] CRC32_MPEG2_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT       = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE    = 32'h0;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DISCARD
   } chk_state_t;

   // One MSB-first shift of the non-reflected CRC-32/MPEG-2 register.
   function automatic logic [31:0] crc32_mpeg2_step(input logic [31:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[31];
      return {crc[30:0], 1'b0} ^ (fb ? CRC32_MPEG2_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32/MPEG-2 checker: runs the serial frame (payload + appended CRC)
// through the CRC register and issues one verdict pulse per frame, one cycle after its last bit.
module crc32_frame_checker
   import crc32_pkg::*;
#(
   parameter int MIN_BITS = 33,
   parameter int MAX_BITS = 65536,
   parameter int CNT_W    = 17
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             data_valid_in,
   input  logic             data_in,
   input  logic             start_in,
   input  logic             last_in,
   output logic             done_out,
   output logic             crc_ok_out,
   output logic             len_err_out,
   output logic             abort_out,
   output logic [CNT_W-1:0] bit_count_out,
   output logic [31:0]      crc_out
);

   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_BITS);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BITS);
   localparam logic [CNT_W-1:0] MAX_P1 = CNT_W'(MAX_BITS + 1);

   chk_state_t       r_state;
   logic [31:0]      r_crc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic             r_ok;
   logic             r_lerr;
   logic             r_abort;
   logic [CNT_W-1:0] r_cnt_out;
   logic [31:0]      r_crc_out;

   chk_state_t       w_state_nxt;
   logic [31:0]      w_frm_crc;
   logic [CNT_W-1:0] w_frm_cnt;
   logic             w_fin;
   logic             w_abort;
   logic             w_lerr;
   logic [31:0]      w_crc_step;
   logic [31:0]      w_crc_first;

   assign w_crc_step  = crc32_mpeg2_step(r_crc, data_in);
   assign w_crc_first = crc32_mpeg2_step(CRC32_INIT, data_in);

   // w_frm_* is the register content including this cycle's bit; it feeds both the
   // running state and, on the last bit, the verdict registers.
   always_comb begin
      w_state_nxt = r_state;
      w_frm_crc   = r_crc;
      w_frm_cnt   = r_cnt;
      w_fin       = 1'b0;
      w_abort     = 1'b0;
      if (data_valid_in) begin
         if (start_in) begin
            w_abort     = (r_state != IDLE);
            w_frm_crc   = w_crc_first;
            w_frm_cnt   = CNT_W'(1);
            w_fin       = last_in;
            w_state_nxt = last_in ? IDLE : RECV;
         end else begin
            case (r_state)
               RECV: begin
                  if (r_cnt == MAX_C) begin
                     w_frm_cnt   = MAX_P1;
                     w_state_nxt = DISCARD;
                  end else begin
                     w_frm_crc = w_crc_step;
                     w_frm_cnt = r_cnt + CNT_W'(1);
                  end
                  if (last_in) begin
                     w_fin       = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
               DISCARD: begin
                  if (last_in) begin
                     w_fin       = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign w_lerr = (w_frm_cnt < MIN_C) | (w_frm_cnt > MAX_C);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= IDLE;
         r_crc   <= CRC32_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_crc   <= w_fin ? CRC32_INIT : w_frm_crc;
         r_cnt   <= w_fin ? '0 : w_frm_cnt;
      end
   end

   // Verdict registers hold until the next completed frame.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
         r_ok      <= 1'b0;
         r_lerr    <= 1'b0;
         r_cnt_out <= '0;
         r_crc_out <= '0;
      end else begin
         r_done  <= w_fin;
         r_abort <= w_abort;
         if (w_fin) begin
            r_ok      <= (w_frm_crc == CRC32_RESIDUE) & ~w_lerr;
            r_lerr    <= w_lerr;
            r_cnt_out <= w_frm_cnt;
            r_crc_out <= w_frm_crc;
         end
      end
   end

   assign done_out      = r_done;
   assign abort_out     = r_abort;
   assign crc_ok_out    = r_ok;
   assign len_err_out   = r_lerr;
   assign bit_count_out = r_cnt_out;
   assign crc_out       = r_crc_out;

endmodule
